// File: rtl/i2c_write_master.sv
// I2C write-only master: START, NUM_BYTES bytes each followed by an ACK slot, STOP.
// A NACK ends the frame early with STOP and raises o_ack_err until the next start.
module i2c_write_master #(
   parameter int NUM_BYTES = 3,
   parameter int CLK_DIV   = 30
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [NUM_BYTES*8-1:0] i_dat,
   output logic                   o_finished,
   output logic                   o_busy,
   output logic                   o_ack_err,
   output logic                   o_sclk,
   inout  wire                    io_sdat
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int MSB = NUM_BYTES*8-1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] ACK   = 3'd3;
   localparam logic [2:0] STOP  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]    state;
   logic [1:0]    quarter;
   logic [DW-1:0] div;
   logic [2:0]    bit_idx;
   logic [BW-1:0] byte_idx;
   logic [MSB:0]  shreg;
   logic          nack;
   logic          ack_err;
   logic          tick;
   logic          sclk;
   logic          sda_low;

   assign tick = (div == DW'(CLK_DIV-1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         quarter  <= '0;
         div      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         nack     <= 1'b0;
         ack_err  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  state    <= START;
                  shreg    <= i_dat;
                  ack_err  <= 1'b0;
                  nack     <= 1'b0;
                  quarter  <= '0;
                  div      <= '0;
                  bit_idx  <= '0;
                  byte_idx <= '0;
               end
            end
            DONE: state <= IDLE;
            default: begin
               div <= tick ? '0 : div + 1'b1;
               if (tick) begin
                  quarter <= quarter + 2'd1;
                  unique case (state)
                     START: begin
                        if (quarter == 2'd1) begin
                           state   <= DATA;
                           quarter <= '0;
                           bit_idx <= 3'd7;
                        end
                     end
                     DATA: begin
                        if (quarter == 2'd3) begin
                           shreg <= shreg << 1;
                           if (bit_idx == 3'd0)
                              state <= ACK;
                           else
                              bit_idx <= bit_idx - 3'd1;
                        end
                     end
                     ACK: begin
                        // Slave answer is taken at the end of the SCL-high q2.
                        if (quarter == 2'd2)
                           nack <= io_sdat;
                        if (quarter == 2'd3) begin
                           if (nack) begin
                              ack_err <= 1'b1;
                              state   <= STOP;
                           end else if (byte_idx == BW'(NUM_BYTES-1)) begin
                              state <= STOP;
                           end else begin
                              byte_idx <= byte_idx + 1'b1;
                              bit_idx  <= 3'd7;
                              state    <= DATA;
                           end
                        end
                     end
                     STOP: begin
                        if (quarter == 2'd2) begin
                           state   <= DONE;
                           quarter <= '0;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   always_comb begin
      sclk    = 1'b1;
      sda_low = 1'b0;
      unique case (state)
         START: sda_low = 1'b1;
         DATA: begin
            sclk    = quarter[1];
            sda_low = ~shreg[MSB];
         end
         ACK:  sclk = quarter[1];
         STOP: begin
            sclk    = (quarter != 2'd0);
            sda_low = (quarter != 2'd2);
         end
         default: ;
      endcase
   end

   assign o_sclk     = sclk;
   assign io_sdat    = sda_low ? 1'b0 : 1'bz;
   assign o_finished = (state == DONE);
   assign o_busy     = (state != IDLE) && (state != DONE);
   assign o_ack_err  = ack_err;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus monitor plus ACK/NACK slave on SDA,
// expected bytes, error flag and finish cycle derived from frame arithmetic.
module tb_i2c_write_master;

   localparam int NB = 3;
   localparam int CD = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [NB*8-1:0] dat = '0;
   logic          finished;
   logic          busy;
   logic          ack_err;
   logic          sclk;
   wire           sda;
   logic          slave_low = 1'b0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_err = 0;

   logic [7:0] bytes_q[$];
   logic [7:0] exp_q[$];
   int         fin_q[$];
   int         starts  = 0;
   int         stops   = 0;
   int         nack_at = -1;

   pullup pu (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   i2c_write_master #(
      .NUM_BYTES(NB),
      .CLK_DIV  (CD)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_dat     (dat),
      .o_finished(finished),
      .o_busy    (busy),
      .o_ack_err (ack_err),
      .o_sclk    (sclk),
      .io_sdat   (sda)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor and slave, sampled mid-cycle away from the DUT's clock edge.
   initial begin
      int   bitcnt;
      int   bidx;
      logic in_frame;
      logic [7:0] sh;
      logic psclk;
      logic psda;
      bitcnt = 0; bidx = 0; in_frame = 1'b0; sh = '0;
      psclk = 1'b1; psda = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bitcnt    = 0;
            in_frame  = 1'b0;
            slave_low = 1'b0;
         end else begin
            if (finished) fin_q.push_back(cyc);
            if (psclk && sclk && psda && !sda) begin
               starts++;
               in_frame = 1'b1;
               bitcnt   = 0;
               bidx     = 0;
            end else if (psclk && sclk && !psda && sda) begin
               stops++;
               in_frame = 1'b0;
            end else if (in_frame && !psclk && sclk) begin
               if (bitcnt < 8) begin
                  sh = {sh[6:0], sda};
                  bitcnt++;
                  if (bitcnt == 8) bytes_q.push_back(sh);
               end else begin
                  bitcnt = 9;
               end
            end else if (in_frame && psclk && !sclk) begin
               if (bitcnt == 8) begin
                  slave_low = (bidx != nack_at);
               end else if (bitcnt == 9) begin
                  slave_low = 1'b0;
                  bitcnt    = 0;
                  bidx++;
               end
            end
         end
         psclk = sclk;
         psda  = sda;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic verify(input string tag, input int nfin,
                         input int fin0, input int err, input int nstart);
      int got;
      check({tag, "_nbytes"}, bytes_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < bytes_q.size()) ? int'(bytes_q[i]) : -1;
         check($sformatf("%s_byte%0d", tag, i), got, int'(exp_q[i]));
      end
      check({tag, "_nfin"}, fin_q.size(), nfin);
      got = (fin_q.size() > 0) ? fin_q[0] : -1;
      check({tag, "_fin_cyc"}, got, fin0);
      check({tag, "_ack_err"}, int'(ack_err), err);
      check({tag, "_starts"}, starts, nstart);
      check({tag, "_stops"}, stops, nstart);
      check({tag, "_idle"}, int'(busy), 0);
   endtask

   task automatic frame(input logic [NB*8-1:0] d, input int nk,
                        input bit inject, input string tag);
      int sent;
      int acc;
      int lat;
      int err;
      bytes_q.delete();
      fin_q.delete();
      exp_q.delete();
      starts  = 0;
      stops   = 0;
      nack_at = nk;
      err  = (nk >= 0 && nk < NB) ? 1 : 0;
      sent = err ? nk + 1 : NB;
      for (int i = 0; i < sent; i++)
         exp_q.push_back(d[(NB-1-i)*8 +: 8]);
      lat = (2 + 36*sent + 3)*CD + 1;
      dat   = d;
      start = 1'b1;
      acc   = cyc;
      check({tag, "_busy_acc"}, int'(busy), 0);
      check({tag, "_err_hold"}, int'(ack_err), last_err);
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_on"}, int'(busy), 1);
      check({tag, "_err_clr"}, int'(ack_err), 0);
      if (inject) begin
         wait_until(acc + 100);
         dat   = ~d;
         start = 1'b1;
         wait_until(acc + 103);
         start = 1'b0;
      end
      wait_until(acc + lat + 4);
      verify(tag, 1, acc + lat, err, 1);
      last_err = err;
   endtask

   initial begin
      int acc;
      int r;
      int nk;
      logic [NB*8-1:0] d;

      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk", int'(sclk), 1);
      check("rst_sda", int'(sda), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_fin", int'(finished), 0);
      check("rst_err", int'(ack_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      frame(24'h340815, -1, 1'b0, "ack_all");
      frame(24'h340815, 1, 1'b0, "nack_b1");
      frame(24'h340815, -1, 1'b1, "busy_start");

      // Reset in the middle of the second byte.
      bytes_q.delete();
      nack_at = -1;
      dat   = 24'h5A_C3_81;
      start = 1'b1;
      acc   = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_until(acc + (2 + 36 + 12)*CD);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sclk", int'(sclk), 1);
      check("mid_rst_sda", int'(sda), 1);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_fin", int'(finished), 0);
      check("mid_rst_err", int'(ack_err), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_err = 0;
      @(posedge clk);
      #1;
      frame(24'h340C00, -1, 1'b0, "post_rst");

      // Start held high: second accept right after the first DONE cycle.
      bytes_q.delete();
      fin_q.delete();
      exp_q.delete();
      starts  = 0;
      stops   = 0;
      nack_at = -1;
      d = 24'h9E_27_C4;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NB; i++)
            exp_q.push_back(d[(NB-1-i)*8 +: 8]);
      dat   = d;
      start = 1'b1;
      acc   = cyc;
      wait_until(acc + 907);
      start = 1'b0;
      wait_until(acc + 915);
      verify("b2b", 2, acc + 453, 0, 2);
      r = (fin_q.size() > 1) ? fin_q[1] : -1;
      check("b2b_fin2_cyc", r, acc + 907);

      for (int t = 0; t < 5; t++) begin
         d  = NB*8'($urandom);
         r  = int'($urandom_range(0, 3));
         nk = (r == 3) ? -1 : r;
         frame(d, nk, 1'b0, $sformatf("rand%0d", t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
